// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Purpose:
//   Shares the single data-memory port between two requesters, M0 (LSU side)
//   and M1 (DMA/debug loader). Each access is sequenced as
//   IDLE -> ISSUE -> WAIT -> RESP. ISSUE drives a one-cycle registered memory
//   request. WAIT counts out the fixed memory latency and captures read data.
//   RESP pulses the winner's rvalid.
//
// Parameters:
//   MEM_LATENCY  cycles from the mem_req_o cycle until mem_rdata_i is valid
//                (1..7)
//   ADDR_W       address width
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), synchronous active-high
//                                reset
//   mX_req_i/we_i/be_i/addr_i/wdata_i  per-master request fields (X = 0, 1)
//   mX_gnt_o                     one-cycle pulse when the access is issued
//   mX_rvalid_o                  one-cycle completion pulse
//   mX_rdata_o                   captured read data, held until the next read
//                                completion for that master
//   m0_stall_o                   m0_req_i & ~m0_rvalid_o
//   mem_req_o/we_o/be_o/addr_o/wdata_o  registered memory request
//   mem_rdata_i                  memory read data
//   busy_o                       FSM not in IDLE
//
// Build option:
//   DATA_BUS_ARB_FIXED_PRIO_EN   when defined, M0 always wins a tie and no
//                                round-robin pointer exists. When undefined,
//                                ties are resolved round-robin.
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m1_req_i,
  input  logic              m0_we_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [3:0]        m1_be_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m0_gnt_o,
  output logic              m1_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  output logic [31:0]       m1_rdata_o,
  output logic              m0_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]        state_reg;
  logic              win_reg;       // 0 = M0, 1 = M1
  logic              we_reg;        // kept past ISSUE to decide on capture
  logic [2:0]        wait_cnt_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [3:0]        mem_be_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;

  logic [1:0]        req;
  logic              tie_pick;      // winner when both masters request
  logic              win_next;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              capture;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;

  assign req = {m1_req_i, m0_req_i};

`ifdef DATA_BUS_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  logic rr_ptr_reg;

  assign tie_pick = rr_ptr_reg;

  // The pointer always favours the master that did not win last time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && (|req)) begin
      rr_ptr_reg <= ~win_next;
    end
  end
`endif

  always_comb begin
    win_next = 1'b0;
    case (req)
      2'b10:   win_next = 1'b1;
      2'b11:   win_next = tie_pick;
      default: win_next = 1'b0;
    endcase
  end

  assign sel_we    = win_next ? m1_we_i    : m0_we_i;
  assign sel_be    = win_next ? m1_be_i    : m0_be_i;
  assign sel_addr  = win_next ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = win_next ? m1_wdata_i : m0_wdata_i;

  // The memory-side registers are loaded on the IDLE->ISSUE edge. As a
  // result, mem_req_o is high exactly while the FSM sits in ISSUE. After
  // ISSUE, req/we/be clear, and addr/wdata keep their last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      win_reg       <= 1'b0;
      we_reg        <= 1'b0;
      wait_cnt_reg  <= 3'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'd0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            win_reg       <= win_next;
            we_reg        <= sel_we;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= sel_we;
            mem_be_reg    <= sel_be;
            mem_addr_reg  <= sel_addr;
            mem_wdata_reg <= sel_wdata;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_req_reg  <= 1'b0;
          mem_we_reg   <= 1'b0;
          mem_be_reg   <= 4'd0;
          wait_cnt_reg <= 3'(MEM_LATENCY - 1);
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_reg == 3'd0) begin
            state_reg <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // The last WAIT cycle is the cycle in which memory read data is valid.
  assign capture = (state_reg == ST_WAIT) && (wait_cnt_reg == 3'd0) && !we_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic [31:0] rdata_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rdata_reg <= 32'd0;
        end else if (capture && (win_reg == 1'(gi))) begin
          rdata_reg <= mem_rdata_i;
        end
      end

      assign gnt[gi]    = (state_reg == ST_ISSUE) && (win_reg == 1'(gi));
      assign rvalid[gi] = (state_reg == ST_RESP)  && (win_reg == 1'(gi));
    end
  endgenerate

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = g_master[0].rdata_reg;
  assign m1_rdata_o  = g_master[1].rdata_reg;
  assign m0_stall_o  = m0_req_i & ~rvalid[0];

  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_be_o    = mem_be_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Directed testbench for data_bus_arbiter.
//
// Two instances are used:
//   u1  MEM_LATENCY = 1; driven by both masters.
//   u3  MEM_LATENCY = 3; M0 only.
//
// Each instance has a small memory model. The model returns a known word only
// in the cycle MEM_LATENCY after mem_req_o. In every other cycle it returns a
// poison value, so any capture in the wrong cycle shows up.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, r3_req;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  // u1 outputs
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // u3 outputs
  logic        m0_gnt3, m1_gnt3, m0_rvalid3, m1_rvalid3, m0_stall3;
  logic [31:0] m0_rdata3, m1_rdata3;
  logic        mem_req3, mem_we3, busy3;
  logic [3:0]  mem_be3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] p1 = 8'd0;
  logic [7:0] p3 = 8'd0;

  logic [1:0]  exp_g, exp_v;
  logic [1:0]  alt_who;   // second grant in the tie sequence
  logic [31:0] exp_m1_rdata;

  always #5 clk = ~clk;

  data_bus_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) u1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m1_req_i(m1_req),
    .m0_we_i(m0_we), .m1_we_i(m1_we),
    .m0_be_i(m0_be), .m1_be_i(m1_be),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
    .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .m0_stall_o(m0_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  data_bus_arbiter #(.MEM_LATENCY(3), .ADDR_W(32)) u3 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(r3_req), .m1_req_i(1'b0),
    .m0_we_i(m0_we), .m1_we_i(1'b0),
    .m0_be_i(m0_be), .m1_be_i(4'd0),
    .m0_addr_i(m0_addr), .m1_addr_i(32'd0),
    .m0_wdata_i(m0_wdata), .m1_wdata_i(32'd0),
    .m0_gnt_o(m0_gnt3), .m1_gnt_o(m1_gnt3),
    .m0_rvalid_o(m0_rvalid3), .m1_rvalid_o(m1_rvalid3),
    .m0_rdata_o(m0_rdata3), .m1_rdata_o(m1_rdata3),
    .m0_stall_o(m0_stall3),
    .mem_req_o(mem_req3), .mem_we_o(mem_we3), .mem_be_o(mem_be3),
    .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3),
    .mem_rdata_i(mem_rdata3), .busy_o(busy3)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    p1 <= {p1[6:0], mem_req};
    p3 <= {p3[6:0], mem_req3};
  end

  assign mem_rdata  = p1[0] ? mem_word(mem_addr)  : 32'hBAD0_BAD0;
  assign mem_rdata3 = p3[2] ? mem_word(mem_addr3) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef DATA_BUS_ARB_FIXED_PRIO_EN
    alt_who      = 2'b01;
    exp_m1_rdata = 32'h0;
`else
    alt_who      = 2'b10;
    exp_m1_rdata = 32'hA5A5_0040;
`endif
    rst = 1'b1; m0_req = 0; m1_req = 0; r3_req = 0;
    m0_we = 0; m1_we = 0; m0_be = 4'hF; m1_be = 4'hF;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_busy",    32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_be",  32'(mem_be), 0);
    chk("rst_mem_adr", mem_addr, 0);
    chk("rst_gnt",     32'({m1_gnt, m0_gnt}), 0);
    chk("rst_rvalid",  32'({m1_rvalid, m0_rvalid}), 0);
    chk("rst_m0_rd",   m0_rdata, 0);
    chk("rst_m1_rd",   m1_rdata, 0);
    rst = 1'b0;
    $display("reset done");

    // ---------------- single M0 read, latency 1 ----------------
    m0_addr = 32'h10; m0_we = 0; m0_be = 4'hF; m0_req = 1;   // cycle t
    tick();                                                  // t+1 ISSUE
    chk("rd_mem_req",  32'(mem_req), 1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we",   32'(mem_we), 0);
    chk("rd_mem_be",   32'(mem_be), 32'hF);
    chk("rd_gnt",      32'({m1_gnt, m0_gnt}), 32'b01);
    chk("rd_busy",     32'(busy), 1);
    chk("rd_stall",    32'(m0_stall), 1);
    tick();                                                  // t+2 WAIT
    chk("rd_req_low",  32'(mem_req), 0);
    chk("rd_be_low",   32'(mem_be), 0);
    chk("rd_addr_hold", mem_addr, 32'h10);
    chk("rd_no_rv",    32'(m0_rvalid), 0);
    tick();                                                  // t+3 RESP
    chk("rd_rvalid",   32'({m1_rvalid, m0_rvalid}), 32'b01);
    chk("rd_rdata",    m0_rdata, 32'hDEADBEEF);
    chk("rd_stall_lo", 32'(m0_stall), 0);
    m0_req = 0;
    tick();                                                  // t+4 IDLE
    chk("rd_idle",     32'(busy), 0);
    chk("rd_rv_once",  32'(m0_rvalid), 0);
    $display("txn M0 read 0x10 -> %h", m0_rdata);

    // ---------------- M1 write ----------------
    m1_addr = 32'h20; m1_we = 1; m1_be = 4'b0100; m1_wdata = 32'h00AB0000; m1_req = 1;
    tick();
    chk("wr_gnt",      32'({m1_gnt, m0_gnt}), 32'b10);
    chk("wr_mem_we",   32'(mem_we), 1);
    chk("wr_mem_be",   32'(mem_be), 32'b0100);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wd",   mem_wdata, 32'h00AB0000);
    tick();
    chk("wr_we_low",   32'(mem_we), 0);
    tick();
    chk("wr_rvalid",   32'({m1_rvalid, m0_rvalid}), 32'b10);
    chk("wr_m1_rd",    m1_rdata, 0);
    chk("wr_m0_rd",    m0_rdata, 32'hDEADBEEF);
    m1_req = 0; m1_we = 0;
    tick();
    chk("wr_rv_once",  32'(m1_rvalid), 0);
    $display("txn M1 write 0x20 be=0100 done");

    // ---------------- simultaneous requests, 3 transactions ----------------
    m0_addr = 32'h30; m0_we = 0; m0_be = 4'hF;
    m1_addr = 32'h40; m1_we = 0; m1_be = 4'hF;
    m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      exp_g = (c == 1 || c == 9) ? 2'b01 : (c == 5) ? alt_who : 2'b00;
      exp_v = (c == 3 || c == 11) ? 2'b01 : (c == 7) ? alt_who : 2'b00;
      chk($sformatf("tie_gnt_c%0d", c), 32'({m1_gnt, m0_gnt}), 32'(exp_g));
      chk($sformatf("tie_rv_c%0d", c),  32'({m1_rvalid, m0_rvalid}), 32'(exp_v));
      if (exp_g != 2'b00) $display("txn tie grant c%0d gnt=%b", c, {m1_gnt, m0_gnt});
    end
    m0_req = 0; m1_req = 0;
    chk("tie_m0_rd", m0_rdata, 32'hA5A5_0030);
    chk("tie_m1_rd", m1_rdata, exp_m1_rdata);
    tick();

    // ---------------- M1 requests during an M0 transaction ----------------
    m0_addr = 32'h50; m0_we = 0; m0_be = 4'hF; m0_req = 1;   // cycle t
    m1_addr = 32'h60; m1_we = 1; m1_be = 4'b0000; m1_wdata = 32'h12345678;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) m1_req = 1;                 // raised during ISSUE
      exp_g = (c == 1) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
      exp_v = (c == 3) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
      chk($sformatf("ovl_gnt_c%0d", c), 32'({m1_gnt, m0_gnt}), 32'(exp_g));
      chk($sformatf("ovl_rv_c%0d", c),  32'({m1_rvalid, m0_rvalid}), 32'(exp_v));
      if (c == 3) m0_req = 0;
      if (c == 4) chk("ovl_idle", 32'(busy), 0);
      if (c == 5) begin
        chk("ovl_be0_req",  32'(mem_req), 1);
        chk("ovl_be0_be",   32'(mem_be), 0);
        chk("ovl_be0_we",   32'(mem_we), 1);
        chk("ovl_be0_addr", mem_addr, 32'h60);
        chk("ovl_be0_wd",   mem_wdata, 32'h12345678);
      end
      if (c == 7) m1_req = 0;
    end
    chk("ovl_m0_rd", m0_rdata, 32'hA5A5_0050);
    chk("ovl_m1_rd", m1_rdata, exp_m1_rdata);
    $display("txn M0 read 0x50 then M1 write 0x60 be=0000 done");

    // ---------------- reset in WAIT ----------------
    m0_addr = 32'h10; m0_we = 0; m0_be = 4'hF; m0_req = 1;
    tick();                                   // ISSUE
    tick();                                   // WAIT
    rst = 1;
    tick();
    rst = 0;
    chk("rstw_busy",   32'(busy), 0);
    chk("rstw_rv",     32'({m1_rvalid, m0_rvalid}), 0);
    chk("rstw_req",    32'(mem_req), 0);
    chk("rstw_m0_rd",  m0_rdata, 0);
    chk("rstw_m1_rd",  m1_rdata, 0);
    tick();                                   // IDLE, request still held
    chk("rstw_gnt",    32'({m1_gnt, m0_gnt}), 32'b01);
    tick();
    tick();
    chk("rstw_rv2",    32'({m1_rvalid, m0_rvalid}), 32'b01);
    chk("rstw_rd2",    m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    tick();
    $display("txn reset in WAIT then M0 read 0x10 -> %h", m0_rdata);

    // ---------------- latency 3 read on u3 ----------------
    m0_addr = 32'h70; m0_we = 0; m0_be = 4'hF; r3_req = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("l3_req_c%0d", c),  32'(mem_req3), 32'(c == 1));
      chk($sformatf("l3_busy_c%0d", c), 32'(busy3), 32'(c <= 5));
      chk($sformatf("l3_rv_c%0d", c),   32'(m0_rvalid3), 32'(c == 5));
      chk($sformatf("l3_rd_c%0d", c),   m0_rdata3, (c >= 5) ? 32'hA5A5_0070 : 32'h0);
      if (c == 1) chk("l3_gnt", 32'({m1_gnt3, m0_gnt3}), 32'b01);
      if (c == 5) r3_req = 0;
    end
    $display("txn L3 M0 read 0x70 -> %h", m0_rdata3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
